// File: rtl/wfifo_burst_ingress_if.sv
// Upstream burst stream bundle for wfifo_burst_ingress: valid/ready handshake
// with per-beat payload, burst length and last marker.
interface wfifo_burst_ingress_if #(
  parameter int DSIZE = 8,
  parameter int LENW  = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [DSIZE-1:0] s_data;
  logic [LENW-1:0]  s_len;
  logic             s_last;

  modport master (output s_valid, output s_data, output s_len, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_len, input s_last, output s_ready);
endinterface

// File: rtl/wfifo_burst_ingress.sv
// Write-side burst ingress: reserves FIFO space for a whole burst before taking beats.
// Optional macro WFIFO_BURST_INGRESS_STATS_EN adds a saturating stall_cycles counter.
module wfifo_burst_ingress #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 6,
  parameter int LENW     = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  wfifo_burst_ingress_if.slave s,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wbin,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic                burst_active,
  output logic                len_err
`ifdef WFIFO_BURST_INGRESS_STATS_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam int PW = ADDRSIZE + 1;
  localparam int LW = LENW + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             winc_q, winc_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             burst_q, burst_d;
  logic             len_err_q, len_err_d;
`ifdef WFIFO_BURST_INGRESS_STATS_EN
  logic [15:0]      stall_q, stall_d;
`endif

  logic [PW-1:0] rbin;
  logic [PW-1:0] used;
  logic [PW-1:0] free;
  logic          room;
  logic          accept;

  // Free space also discounts the write currently on winc, which wbin does not yet show.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
    used = wbin - rbin;
    free = DEPTH - used - PW'(winc_q);
    room = (free >= PW'(len_q));
  end

  assign s.s_ready = burst_q & ~wfull;
  assign accept    = s.s_valid & s.s_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    len_err_d = len_err_q;
    winc_d    = accept;
    wdata_d   = accept ? s.s_data : wdata_q;
    unique case (state_q)
      IDLE: begin
        if (s.s_valid) begin
          len_d   = LW'(s.s_len) + LW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (room) begin
          rem_d   = len_q;
          state_d = BURST;
        end
      end
      BURST: begin
        // The beat counter alone ends the burst; s_last only feeds the framing flag.
        if (accept) begin
          rem_d = rem_q - LW'(1);
          if (s.s_last != (rem_q == LW'(1))) len_err_d = 1'b1;
          if (rem_q == LW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    burst_d = (state_d == BURST);
  end

`ifdef WFIFO_BURST_INGRESS_STATS_EN
  always_comb begin
    stall_d = stall_q;
    if ((state_q == WAIT) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end
`endif

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      winc_q    <= 1'b0;
      wdata_q   <= '0;
      burst_q   <= 1'b0;
      len_err_q <= 1'b0;
`ifdef WFIFO_BURST_INGRESS_STATS_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      winc_q    <= winc_d;
      wdata_q   <= wdata_d;
      burst_q   <= burst_d;
      len_err_q <= len_err_d;
`ifdef WFIFO_BURST_INGRESS_STATS_EN
      stall_q   <= stall_d;
`endif
    end
  end

  assign winc         = winc_q;
  assign wdata        = wdata_q;
  assign burst_active = burst_q;
  assign len_err      = len_err_q;
`ifdef WFIFO_BURST_INGRESS_STATS_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wfifo_burst_ingress.sv
// Bench for wfifo_burst_ingress: directed scenarios plus randomized bursts against
// a burst-level model of space reservation, with a simple FIFO pointer environment.
module tb_wfifo_burst_ingress;

  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 6;
  localparam int LENW     = 4;
  localparam int DEPTH    = 64;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  wfifo_burst_ingress_if #(.DSIZE(DSIZE), .LENW(LENW)) s_if ();

  logic             wfull;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             burst_active;
  logic             len_err;
  logic [ADDRSIZE:0] wbin = '0;
  logic [ADDRSIZE:0] rbin = '0;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] used;
`ifdef WFIFO_BURST_INGRESS_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  wfifo_burst_ingress #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .LENW(LENW)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .s            (s_if.slave),
    .wfull        (wfull),
    .wbin         (wbin),
    .wq2_rptr     (wq2_rptr),
    .winc         (winc),
    .wdata        (wdata),
    .burst_active (burst_active),
    .len_err      (len_err)
`ifdef WFIFO_BURST_INGRESS_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // FIFO environment: binary pointers, Gray read pointer, reader that drains at random.
  logic             ptr_load = 1'b0;
  logic [ADDRSIZE:0] wbin_ld = '0;
  logic [ADDRSIZE:0] rbin_ld = '0;
  logic             rptr_set = 1'b0;
  logic [ADDRSIZE:0] rptr_val = '0;
  logic             drain_en = 1'b0;

  assign used     = wbin - rbin;
  assign wfull    = (used == 7'(DEPTH));
  assign wq2_rptr = rbin ^ (rbin >> 1);

  always @(posedge wclk) begin
    if (ptr_load) begin
      wbin <= wbin_ld;
      rbin <= rbin_ld;
    end else begin
      if (winc && !wfull) wbin <= wbin + 7'd1;
      if (rptr_set) rbin <= rptr_val;
      else if (drain_en && (used != 0) && ($urandom_range(0, 2) == 0)) rbin <= rbin + 7'd1;
    end
  end

  logic       acc_seen = 1'b0;
  logic [7:0] wlog[$];
  int         wfull_burst_cycles = 0;

  always @(posedge wclk) begin
    acc_seen <= s_if.s_valid & s_if.s_ready;
    if (winc) wlog.push_back(wdata);
    if (wfull && burst_active) wfull_burst_cycles <= wfull_burst_cycles + 1;
  end

  // Burst-level model: a pending request waits until the whole burst fits, then that many beats are owed.
  int         m_need = 0;
  int         m_left = 0;
  logic       m_winc = 1'b0;
  logic [7:0] m_wdata = '0;
  logic       m_err = 1'b0;
  int         m_stall = 0;

  always @(posedge wclk) begin
    int  free_i;
    logic acc;
    if (wrst) begin
      m_need = 0; m_left = 0; m_winc = 1'b0; m_wdata = '0; m_err = 1'b0; m_stall = 0;
    end else begin
      acc    = s_if.s_valid && (m_left > 0) && !wfull;
      free_i = DEPTH - int'(used) - int'(m_winc);
      if (m_left > 0) begin
        if (acc) begin
          if (s_if.s_last != (m_left == 1)) m_err = 1'b1;
          m_left = m_left - 1;
        end
      end else if (m_need > 0) begin
        if (m_stall < 65535) m_stall = m_stall + 1;
        if (free_i >= m_need) begin
          m_left = m_need;
          m_need = 0;
        end
      end else if (s_if.s_valid) begin
        m_need = int'(s_if.s_len) + 1;
      end
      m_winc = acc;
      if (acc) m_wdata = s_if.s_data;
    end
  end

  int   checks = 0;
  int   passes = 0;
  logic checking = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic compareModel();
    checkOutput("burst_active", 32'(burst_active), 32'(m_left > 0));
    checkOutput("s_ready", 32'(s_if.s_ready), 32'((m_left > 0) && !wfull));
    checkOutput("winc", 32'(winc), 32'(m_winc));
    checkOutput("wdata", 32'(wdata), 32'(m_wdata));
    checkOutput("len_err", 32'(len_err), 32'(m_err));
`ifdef WFIFO_BURST_INGRESS_STATS_EN
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
  endtask

  // Every clock passes through here: compare on the falling edge, then drive 1 ns after the rising edge.
  task automatic cycle();
    @(negedge wclk);
    if (checking) compareModel();
    @(posedge wclk);
    #1;
  endtask

  task automatic loadPointers(input int w, input int r);
    ptr_load = 1'b1;
    wbin_ld  = 7'(w);
    rbin_ld  = 7'(r);
    cycle();
    ptr_load = 1'b0;
  endtask

  task automatic setReadPointer(input int r);
    rptr_set = 1'b1;
    rptr_val = 7'(r);
    cycle();
    rptr_set = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input logic [7:0] base, input int bad_last,
                               input int stop_after, input int budget,
                               output int nacc, output int first_acc, output int ncyc,
                               output logic [15:0] err_hist);
    int i;
    int c;
    i = 0; c = 0; first_acc = -1; err_hist = '0;
    s_if.s_len = 4'(len - 1);
    while ((i < stop_after) && (c < budget)) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = base + 8'(i);
      s_if.s_last  = (bad_last >= 0) ? (i == bad_last) : (i == len - 1);
      cycle();
      c++;
      if (acc_seen) begin
        if (first_acc < 0) first_acc = c;
        err_hist[i] = len_err;
        i++;
      end
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    nacc = i;
    ncyc = c;
    if (c >= budget) checkOutput("burst_budget", 32'(i), 32'(stop_after));
  endtask

  initial begin
    int          nacc, first_acc, ncyc, base_wr, wf0;
    logic [15:0] eh;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_len   = '0;
    s_if.s_last  = 1'b0;

    wrst = 1'b1;
    repeat (2) cycle();
    wrst = 1'b0;
    checking = 1'b1;
    checkOutput("rst_s_ready", 32'(s_if.s_ready), 32'd0);
    checkOutput("rst_winc", 32'(winc), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    checkOutput("rst_burst_active", 32'(burst_active), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);

    // Empty FIFO, 4-beat burst: one WAIT cycle, then 4 back-to-back writes.
    base_wr = wlog.size();
    applyStimulus(4, 8'hA0, -1, 4, 40, nacc, first_acc, ncyc, eh);
    repeat (2) cycle();
    checkOutput("t1_first_accept", 32'(first_acc), 32'd3);
    checkOutput("t1_cycles", 32'(ncyc), 32'd6);
    checkOutput("t1_writes", 32'(wlog.size() - base_wr), 32'd4);
    for (int k = 0; k < 4; k++) checkOutput("t1_wdata", 32'(wlog[base_wr + k]), 32'(8'hA0 + k));
    checkOutput("t1_len_err", 32'(len_err), 32'd0);

    // used=60 blocks an 8-beat burst until the reader moves to 4.
    loadPointers(60, 0);
    s_if.s_valid = 1'b1; s_if.s_len = 4'd7; s_if.s_data = 8'hB0; s_if.s_last = 1'b0;
    repeat (5) cycle();
    checkOutput("t2_wait_ready", 32'(s_if.s_ready), 32'd0);
    checkOutput("t2_wait_active", 32'(burst_active), 32'd0);
    setReadPointer(4);
    checkOutput("t2_still_wait", 32'(burst_active), 32'd0);
    cycle();
    checkOutput("t2_admitted", 32'(burst_active), 32'd1);
    wf0 = wfull_burst_cycles;
    base_wr = wlog.size();
    applyStimulus(8, 8'hB0, -1, 8, 40, nacc, first_acc, ncyc, eh);
    repeat (2) cycle();
    checkOutput("t2_writes", 32'(wlog.size() - base_wr), 32'd8);
    checkOutput("t2_no_wfull", 32'(wfull_burst_cycles - wf0), 32'd0);

    // Wrapped pointers, used=63: one beat fits, two do not.
    loadPointers(66, 3);
    base_wr = wlog.size();
    applyStimulus(1, 8'hC0, -1, 1, 40, nacc, first_acc, ncyc, eh);
    repeat (2) cycle();
    checkOutput("t3_first_accept", 32'(first_acc), 32'd3);
    checkOutput("t3_writes", 32'(wlog.size() - base_wr), 32'd1);
    loadPointers(66, 3);
    s_if.s_valid = 1'b1; s_if.s_len = 4'd1; s_if.s_data = 8'hC1; s_if.s_last = 1'b0;
    repeat (20) cycle();
    checkOutput("t3_blocked_active", 32'(burst_active), 32'd0);
    checkOutput("t3_blocked_ready", 32'(s_if.s_ready), 32'd0);
    setReadPointer(10);
    applyStimulus(2, 8'hC1, -1, 2, 40, nacc, first_acc, ncyc, eh);
    checkOutput("t3_release_beats", 32'(nacc), 32'd2);

    // Early s_last on beat 2 of 3: flag rises after that beat, burst still runs to 3 beats.
    loadPointers(0, 0);
    base_wr = wlog.size();
    applyStimulus(3, 8'hD0, 1, 3, 40, nacc, first_acc, ncyc, eh);
    checkOutput("t4_err_beat1", 32'(eh[0]), 32'd0);
    checkOutput("t4_err_beat2", 32'(eh[1]), 32'd1);
    repeat (2) cycle();
    checkOutput("t4_writes", 32'(wlog.size() - base_wr), 32'd3);
    checkOutput("t4_idle", 32'(burst_active), 32'd0);

    // Reset after 2 of 5 beats, then a fresh burst.
    applyStimulus(5, 8'hE0, -1, 2, 40, nacc, first_acc, ncyc, eh);
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    checkOutput("t5_s_ready", 32'(s_if.s_ready), 32'd0);
    checkOutput("t5_winc", 32'(winc), 32'd0);
    checkOutput("t5_len_err", 32'(len_err), 32'd0);
    checkOutput("t5_active", 32'(burst_active), 32'd0);
    base_wr = wlog.size();
    applyStimulus(3, 8'hF0, -1, 3, 40, nacc, first_acc, ncyc, eh);
    repeat (2) cycle();
    checkOutput("t5_new_first", 32'(first_acc), 32'd3);
    checkOutput("t5_new_writes", 32'(wlog.size() - base_wr), 32'd3);

`ifdef WFIFO_BURST_INGRESS_STATS_EN
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    loadPointers(64, 0);
    s_if.s_valid = 1'b1; s_if.s_len = 4'd0; s_if.s_data = 8'h55; s_if.s_last = 1'b1;
    repeat (11) cycle();
    checkOutput("stats_stall10", 32'(stall_cycles), 32'd10);
    setReadPointer(8);
    applyStimulus(1, 8'h55, -1, 1, 40, nacc, first_acc, ncyc, eh);
`endif

    // Randomized bursts with a draining reader.
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    begin
      int w0;
      w0 = $urandom_range(0, 127);
      loadPointers(w0, (w0 - $urandom_range(0, DEPTH)) & 127);
    end
    drain_en = 1'b1;
    for (int b = 0; b < 60; b++) begin
      int len;
      int bad;
      len = $urandom_range(1, 16);
      bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      applyStimulus(len, 8'($urandom), bad, len, 600, nacc, first_acc, ncyc, eh);
      repeat ($urandom_range(0, 2)) cycle();
    end
    drain_en = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
